video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Parametrised video timing generator and test-pattern source for the HDMI/DVI output path. Produces horizontal/vertical counters, sync, data-enable, frame/line strobes and an 8-bit-per-channel RGB pattern, all registered and aligned on one pixel clock. It feeds the per-channel TMDS encoders directly and replaces fixed 640x480 counter logic with a generator configurable to any progressive mode.

## Interface
- H_ACTIVE, 640, active pixels per line (must be a multiple of 8)
- H_FP, 16, horizontal front porch, pixels
- H_SYNC, 96, horizontal sync width, pixels
- H_BP, 48, horizontal back porch, pixels
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch, lines
- V_SYNC, 2, vertical sync width, lines
- V_BP, 33, vertical back porch, lines
- HS_POL, 1, hsync active level
- VS_POL, 1, vsync active level
- CW, 12, counter width; must satisfy 2^CW > max(H_TOTAL, V_TOTAL)

- clk  in  1  pixel clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ce  in  1  pixel enable; counters and outputs advance only when high
- mode  in  2  pattern select, latched at frame boundary
- hsync  out  1  horizontal sync, polarity HS_POL
- vsync  out  1  vertical sync, polarity VS_POL
- de  out  1  high inside active area
- x  out  CW  horizontal position, 0..H_TOTAL-1
- y  out  CW  vertical position, 0..V_TOTAL-1
- line_start  out  1  one-ce-cycle strobe at x==0
- frame_start  out  1  one-ce-cycle strobe at x==0, y==0
- red, green, blue  out  8 each  pattern pixel, 0 when de low

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Internal h counter 0..H_TOTAL-1, wraps to 0; v increments on h wrap, wraps 0 after V_TOTAL-1. Both advance only on ce.
- Region order: active, front porch, sync, back porch (active starts at 0).
- de = (h < H_ACTIVE) && (v < V_ACTIVE).
- hsync active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vsync active for whole lines V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, switching with h==0.
- Active mode register: loaded from mode on the ce cycle where h==H_TOTAL-1 and v==V_TOTAL-1; mode changes mid-frame never tear a frame. Reset value 0.
- Patterns (active area only):
  - 0 gradient: red=x[7:0], green=y[7:0], blue=x[7:0]^y[7:0].
  - 1 colour bars: 8 bars each H_ACTIVE/8 wide, left to right white, yellow, cyan, green, magenta, red, blue, black; channel levels 8'hFF/8'h00. Bar index via internal bar counter; no divider.
  - 2 flat grey: all channels 8'h80.
  - 3 checkerboard 16x16: all channels 8'hFF when x[4]^y[4], else 8'h00.

## Timing
- All outputs registered; latency 1 clk from counter state: on the ce cycle in which the counter holds (h,v), outputs show x=h, y=v and corresponding de/sync/strobes/RGB on the next clk edge.
- ce low: counters and all outputs hold previous values (strobes held too; consumers qualify with ce).
- Reset (asynchronous assert, any time incl. mid-frame): h=v=0, mode reg 0, hsync=~HS_POL, vsync=~VS_POL, de=0, x=y=0, line_start=frame_start=0, RGB=0. First ce cycle after release outputs (0,0): de=1, line_start=1, frame_start=1.
- Wrap: (H_TOTAL-1, V_TOTAL-1) is followed directly by (0,0) with frame_start=1; no idle cycle.

## Test plan
- Reset, ce=1 constant, defaults: first output x=0,y=0,de=1,frame_start=1; next frame_start exactly 420000 clks later.
- Default line: hsync high for x=656..751 (96 clks), de high x=0..639 on y<480, de low all of y=480..524; vsync high exactly for y=490..491, 1600 clks.
- ce toggled 1-0-1-0: outputs advance once per ce-high cycle, hold on ce-low; frame length 840000 clks.
- mode=0->1 written mid-frame: current frame stays gradient (pixel (10,5): R=10,G=5,B=15); next frame bar 0 (x=0) RGB=FF/FF/FF, x=80 RGB=FF/FF/00, x=639 RGB=00/00/00.
- mode=3: pixel (16,0) all FF, (16,16) all 00; blanking pixel (700,10) RGB=0.
- rst_n low mid-frame at (300,200) for 3 clks: outputs go to reset values immediately (async), restart at (0,0) with frame_start=1; HS_POL=0 variant: hsync idles high.

Source files
------------

// File: rtl/video_timing_gen_if.sv
// Video timing bus: pixel enable and pattern select in, sync/position/RGB out.
// The generator takes the master side and the TMDS path takes the slave side.
interface video_timing_gen_if #(
    parameter int CW = 12
);
    logic          ce;
    logic [1:0]    mode;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          line_start;
    logic          frame_start;
    logic [7:0]    red;
    logic [7:0]    green;
    logic [7:0]    blue;

    modport master (
        input  ce, mode,
        output hsync, vsync, de, x, y, line_start, frame_start, red, green, blue
    );

    modport slave (
        output ce, mode,
        input  hsync, vsync, de, x, y, line_start, frame_start, red, green, blue
    );
endinterface

// File: rtl/video_timing_gen.sv
// Progressive-mode video timing generator with built-in test patterns.
// Outputs are registered one clk behind the h/v counter state.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CW       = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    video_timing_gen_if.master  vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] BAR_LAST = CW'(H_ACTIVE / 8 - 1);

    logic [CW-1:0] h_q, h_d, v_q, v_d;
    logic [CW-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    logic [1:0]    mode_q, mode_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic          line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic [7:0]    red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic          last_h, last_v, active;

    always_comb begin
        h_d           = h_q;
        v_d           = v_q;
        bar_cnt_d     = bar_cnt_q;
        bar_idx_d     = bar_idx_q;
        mode_d        = mode_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        x_d           = x_q;
        y_d           = y_q;
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;
        red_d         = red_q;
        green_d       = green_q;
        blue_d        = blue_q;
        last_h        = (h_q == H_LAST);
        last_v        = (v_q == V_LAST);
        active        = (h_q < H_ACT) && (v_q < V_ACT);

        if (vif.ce) begin
            h_d = last_h ? '0 : h_q + CW'(1);
            if (last_h)
                v_d = last_v ? '0 : v_q + CW'(1);
            // Pattern only switches on the last pixel of a frame so no frame tears.
            if (last_h && last_v)
                mode_d = vif.mode;

            // Bar counter tracks h so the bar index needs no divider.
            if (last_h) begin
                bar_cnt_d = '0;
                bar_idx_d = '0;
            end else if (bar_cnt_q == BAR_LAST) begin
                bar_cnt_d = '0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_cnt_d = bar_cnt_q + CW'(1);
            end

            hsync_d       = ((h_q >= HS_BEG) && (h_q < HS_END)) ? HS_POL : ~HS_POL;
            vsync_d       = ((v_q >= VS_BEG) && (v_q < VS_END)) ? VS_POL : ~VS_POL;
            de_d          = active;
            x_d           = h_q;
            y_d           = v_q;
            line_start_d  = (h_q == '0);
            frame_start_d = (h_q == '0) && (v_q == '0);

            red_d   = 8'h00;
            green_d = 8'h00;
            blue_d  = 8'h00;
            if (active) begin
                case (mode_q)
                    2'd0: begin
                        red_d   = h_q[7:0];
                        green_d = v_q[7:0];
                        blue_d  = h_q[7:0] ^ v_q[7:0];
                    end
                    // Bar order white..black maps each channel onto one index bit.
                    2'd1: begin
                        red_d   = {8{~bar_idx_q[1]}};
                        green_d = {8{~bar_idx_q[2]}};
                        blue_d  = {8{~bar_idx_q[0]}};
                    end
                    2'd2: begin
                        red_d   = 8'h80;
                        green_d = 8'h80;
                        blue_d  = 8'h80;
                    end
                    default: begin
                        red_d   = {8{h_q[4] ^ v_q[4]}};
                        green_d = {8{h_q[4] ^ v_q[4]}};
                        blue_d  = {8{h_q[4] ^ v_q[4]}};
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q           <= '0;
            v_q           <= '0;
            bar_cnt_q     <= '0;
            bar_idx_q     <= '0;
            mode_q        <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            bar_cnt_q     <= bar_cnt_d;
            bar_idx_q     <= bar_idx_d;
            mode_q        <= mode_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
        end
    end

    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    assign vif.de          = de_q;
    assign vif.x           = x_q;
    assign vif.y           = y_q;
    assign vif.line_start  = line_start_q;
    assign vif.frame_start = frame_start_q;
    assign vif.red         = red_q;
    assign vif.green       = green_q;
    assign vif.blue        = blue_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a reduced 80x47 mode; a reference pixel model
// feeds a scoreboard queue that is drained against the registered outputs.
module tb_video_timing_gen;
    localparam int HA = 64, HF = 4, HS = 8, HB = 4;
    localparam int VA = 40, VF = 2, VS = 2, VB = 3;
    localparam int CW = 12;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int BW = HA / 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ce_r;
    logic [1:0] mode_r;

    always #5 clk = ~clk;

    video_timing_gen_if #(.CW(CW)) vif ();
    video_timing_gen_if #(.CW(CW)) vif_n ();
    assign vif.ce     = ce_r;
    assign vif.mode   = mode_r;
    assign vif_n.ce   = ce_r;
    assign vif_n.mode = mode_r;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW)
    ) u_dut (.clk(clk), .rst_n(rst_n), .vif(vif));

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)
    ) u_dut_n (.clk(clk), .rst_n(rst_n), .vif(vif_n));

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          de;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          ls;
        logic          fs;
        logic [7:0]    r;
        logic [7:0]    g;
        logic [7:0]    b;
    } pix_t;

    pix_t sb[$];
    pix_t last;
    int   mh, mv, mmode;
    int   errors = 0;
    int   checks = 0;

    function automatic pix_t model(int h, int v, int md);
        pix_t        p;
        logic [23:0] col;
        p    = '0;
        p.hs = (h >= HA + HF) && (h < HA + HF + HS);
        p.vs = (v >= VA + VF) && (v < VA + VF + VS);
        p.de = (h < HA) && (v < VA);
        p.x  = CW'(h);
        p.y  = CW'(v);
        p.ls = (h == 0);
        p.fs = (h == 0) && (v == 0);
        if (p.de) begin
            case (md)
                0: col = {8'(h), 8'(v), 8'(h ^ v)};
                1: case (h / BW)
                       0: col = 24'hFFFFFF;
                       1: col = 24'hFFFF00;
                       2: col = 24'h00FFFF;
                       3: col = 24'h00FF00;
                       4: col = 24'hFF00FF;
                       5: col = 24'hFF0000;
                       6: col = 24'h0000FF;
                       default: col = 24'h000000;
                   endcase
                2: col = 24'h808080;
                default: col = (((h / 16) + (v / 16)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
            endcase
            {p.r, p.g, p.b} = col;
        end
        return p;
    endfunction

    function automatic pix_t obs();
        pix_t p;
        p = {vif.hsync, vif.vsync, vif.de, vif.x, vif.y, vif.line_start,
             vif.frame_start, vif.red, vif.green, vif.blue};
        return p;
    endfunction

    task automatic reset_model();
        mh = 0; mv = 0; mmode = 0;
        last = '0;
        sb.delete();
    endtask

    task automatic cycle(input logic c, input logic [1:0] md, output pix_t e, output pix_t o);
        pix_t p;
        ce_r   = c;
        mode_r = md;
        if (c) begin
            p = model(mh, mv, mmode);
            if (mh == HT - 1 && mv == VT - 1) mmode = int'(md);
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            last = p;
        end
        sb.push_back(last);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        o = obs();
    endtask

    task automatic test_reset();
        pix_t e, o;
        rst_n = 1'b0; ce_r = 1'b1; mode_r = 2'd0;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs() !== pix_t'('0)) begin
            errors++; $display("FAIL reset_state: got %h want %h", obs(), pix_t'('0));
        end
        checks++;
        if ({vif_n.hsync, vif_n.vsync} !== 2'b11) begin
            errors++; $display("FAIL reset_pol0_idle: got %b want 11", {vif_n.hsync, vif_n.vsync});
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 2'd0, e, o);
        checks++;
        if ({o.de, o.ls, o.fs, o.x, o.y} !== {3'b111, {CW{1'b0}}, {CW{1'b0}}}) begin
            errors++; $display("FAIL first_pixel: got de/ls/fs=%b%b%b x=%0d y=%0d want 111 0 0",
                               o.de, o.ls, o.fs, o.x, o.y);
        end
        checks++;
        if (o !== e) begin errors++; $display("FAIL first_px: got %h want %h", o, e); end
    endtask

    task automatic test_frame();
        pix_t e, o;
        int   gap = -1, hs_cnt = 0, vs_cnt = 0, de_cnt = 0, de_blank = 0;
        for (int n = 0; n <= HT * VT; n++) begin
            cycle(1'b1, 2'd0, e, o);
            checks++;
            if (o !== e) begin errors++; $display("FAIL frame_px: got %h want %h", o, e); end
            checks++;
            if ({vif_n.hsync, vif_n.vsync} !== ~{e.hs, e.vs}) begin
                errors++; $display("FAIL pol0_sync: got %b want %b", {vif_n.hsync, vif_n.vsync}, ~{e.hs, e.vs});
            end
            if (o.fs && gap < 0) gap = n + 1;
            if (n < HT * VT) begin
                if (o.hs && o.y == CW'(0)) hs_cnt++;
                if (o.vs) vs_cnt++;
                if (o.de) de_cnt++;
                if (o.de && o.y >= CW'(VA)) de_blank++;
            end
        end
        checks++;
        if (gap !== HT * VT) begin errors++; $display("FAIL frame_period: got %0d want %0d", gap, HT * VT); end
        checks++;
        if (hs_cnt !== HS) begin errors++; $display("FAIL hsync_width: got %0d want %0d", hs_cnt, HS); end
        checks++;
        if (vs_cnt !== VS * HT) begin errors++; $display("FAIL vsync_clks: got %0d want %0d", vs_cnt, VS * HT); end
        checks++;
        if (de_cnt !== HA * VA) begin errors++; $display("FAIL de_count: got %0d want %0d", de_cnt, HA * VA); end
        checks++;
        if (de_blank !== 0) begin errors++; $display("FAIL de_vblank: got %0d want 0", de_blank); end
    endtask

    task automatic test_ce_toggle();
        pix_t e, o;
        logic prev_fs = 1'b1;
        int   rise0 = -1, rise1 = -1;
        for (int n = 0; n < 4 * HT * VT + 4; n++) begin
            cycle(n % 2 == 0, 2'd0, e, o);
            checks++;
            if (o !== e) begin errors++; $display("FAIL ce_px: got %h want %h", o, e); end
            if (o.fs && !prev_fs) begin
                if (rise0 < 0) rise0 = n;
                else if (rise1 < 0) rise1 = n;
            end
            prev_fs = o.fs;
        end
        checks++;
        if (rise1 - rise0 !== 2 * HT * VT || rise0 < 0) begin
            errors++; $display("FAIL ce_frame_len: got %0d want %0d", rise1 - rise0, 2 * HT * VT);
        end
    endtask

    task automatic test_mode_switch();
        pix_t e, o;
        int   n = 0, hits = 0;
        logic nf = 1'b0;
        while (!(mh == 0 && mv == 3) && n < 2 * HT * VT) begin
            cycle(1'b1, 2'd0, e, o);
            checks++;
            if (o !== e) begin errors++; $display("FAIL mode_pre_px: got %h want %h", o, e); end
            n++;
        end
        checks++;
        if (n >= 2 * HT * VT) begin errors++; $display("FAIL mode_wait: got timeout want position (0,3)"); end
        for (int k = 0; k < HT * VT; k++) begin
            cycle(1'b1, 2'd1, e, o);
            checks++;
            if (o !== e) begin errors++; $display("FAIL mode_px: got %h want %h", o, e); end
            if (o.fs) nf = 1'b1;
            if (!nf && o.x == CW'(10) && o.y == CW'(5)) begin
                hits++; checks++;
                if ({o.r, o.g, o.b} !== 24'h0A050F) begin
                    errors++; $display("FAIL grad_10_5: got %h want 0a050f", {o.r, o.g, o.b});
                end
            end
            if (nf && o.y == CW'(0) && o.x == CW'(0)) begin
                hits++; checks++;
                if ({o.r, o.g, o.b} !== 24'hFFFFFF) begin
                    errors++; $display("FAIL bar_white: got %h want ffffff", {o.r, o.g, o.b});
                end
            end
            if (nf && o.y == CW'(0) && o.x == CW'(BW)) begin
                hits++; checks++;
                if ({o.r, o.g, o.b} !== 24'hFFFF00) begin
                    errors++; $display("FAIL bar_yellow: got %h want ffff00", {o.r, o.g, o.b});
                end
            end
            if (nf && o.y == CW'(0) && o.x == CW'(HA - 1)) begin
                hits++; checks++;
                if ({o.r, o.g, o.b} !== 24'h000000) begin
                    errors++; $display("FAIL bar_black: got %h want 000000", {o.r, o.g, o.b});
                end
            end
        end
        checks++;
        if (hits !== 4) begin errors++; $display("FAIL mode_hits: got %0d want 4", hits); end
    endtask

    task automatic test_checker();
        pix_t e, o;
        int   hits = 0;
        logic nf = 1'b0;
        for (int k = 0; k < HT * VT + 17 * HT; k++) begin
            cycle(1'b1, 2'd3, e, o);
            checks++;
            if (o !== e) begin errors++; $display("FAIL chk_px: got %h want %h", o, e); end
            if (o.fs) nf = 1'b1;
            if (nf && o.x == CW'(16) && o.y == CW'(0)) begin
                hits++; checks++;
                if ({o.r, o.g, o.b} !== 24'hFFFFFF) begin
                    errors++; $display("FAIL chk_16_0: got %h want ffffff", {o.r, o.g, o.b});
                end
            end
            if (nf && o.x == CW'(16) && o.y == CW'(16)) begin
                hits++; checks++;
                if ({o.r, o.g, o.b} !== 24'h000000) begin
                    errors++; $display("FAIL chk_16_16: got %h want 000000", {o.r, o.g, o.b});
                end
            end
            if (nf && o.x == CW'(HA + 4) && o.y == CW'(10)) begin
                hits++; checks++;
                if ({o.de, o.r, o.g, o.b} !== 25'h0) begin
                    errors++; $display("FAIL chk_blank: got %h want 0", {o.de, o.r, o.g, o.b});
                end
            end
        end
        checks++;
        if (hits !== 3) begin errors++; $display("FAIL chk_hits: got %0d want 3", hits); end
    endtask

    task automatic test_reset_mid();
        pix_t e, o;
        int   n = 0;
        while (!(mh == 30 && mv == 20) && n < 2 * HT * VT) begin
            cycle(1'b1, 2'd3, e, o);
            checks++;
            if (o !== e) begin errors++; $display("FAIL rmid_pre_px: got %h want %h", o, e); end
            n++;
        end
        checks++;
        if (n >= 2 * HT * VT) begin errors++; $display("FAIL rmid_wait: got timeout want position (30,20)"); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== pix_t'('0)) begin
            errors++; $display("FAIL rmid_async: got %h want %h", obs(), pix_t'('0));
        end
        checks++;
        if ({vif_n.hsync, vif_n.vsync} !== 2'b11) begin
            errors++; $display("FAIL rmid_pol0_idle: got %b want 11", {vif_n.hsync, vif_n.vsync});
        end
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs() !== pix_t'('0)) begin
            errors++; $display("FAIL rmid_hold: got %h want %h", obs(), pix_t'('0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2 * HT; k++) begin
            cycle(1'b1, 2'd3, e, o);
            if (k == 0) begin
                checks++;
                if ({o.fs, o.x, o.y} !== {1'b1, {CW{1'b0}}, {CW{1'b0}}}) begin
                    errors++; $display("FAIL rmid_restart: got fs=%b x=%0d y=%0d want 1 0 0", o.fs, o.x, o.y);
                end
            end
            checks++;
            if (o !== e) begin errors++; $display("FAIL rmid_px: got %h want %h", o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_ce_toggle();
        test_mode_switch();
        test_checker();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
